// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the LSB/fetch to byte-wide RAM controller.
package mem_ctrl_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam logic [31:0] MC_IO_BASE     = 32'h0003_0000;
  localparam int unsigned MC_FETCH_BYTES = 4;

  // Request width codes (byte counts)
  localparam logic [2:0] W_NULL = 3'd0;
  localparam logic [2:0] W_BYTE = 3'd1;
  localparam logic [2:0] W_HALF = 3'd2;
  localparam logic [2:0] W_WORD = 3'd4;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_LOAD  = 2'd1,
    MC_STORE = 2'd2,
    MC_FETCH = 2'd3
  } mc_state_e;

  // Latched request payload: byte count and store word
  typedef struct packed {
    logic [2:0]      width;
    logic [XLEN-1:0] data;
  } mc_req_t;

endpackage

// File: rtl/mem_byte_shift.sv
// Byte-lane serialiser (word -> byte) and assembler (byte -> word lane).
module mem_byte_shift
  import mem_ctrl_pkg::*;
(
  input  logic [XLEN-1:0]   tx_word,
  input  logic [1:0]        tx_lane,
  input  logic [XLEN-1:0]   rx_word,
  input  logic [1:0]        rx_lane,
  input  logic [BYTE_W-1:0] rx_byte,
  output logic [BYTE_W-1:0] tx_byte,
  output logic [XLEN-1:0]   rx_merged
);

  // Pick the outgoing byte and drop the incoming byte into its lane
  always_comb begin
    tx_byte                           = tx_word[{tx_lane, 3'b000} +: BYTE_W];
    rx_merged                         = rx_word;
    rx_merged[{rx_lane, 3'b000} +: BYTE_W] = rx_byte;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: serves LSB load/store and instruction fetch over a byte-wide RAM port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE     = MC_IO_BASE,
  parameter int unsigned FETCH_BYTES = MC_FETCH_BYTES
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              go_work,
  input  logic              l_or_s,
  input  logic [2:0]        width,
  input  logic [XLEN-1:0]   address,
  input  logic [XLEN-1:0]   value_store,
  output logic              received,
  output logic              has_result,
  output logic [XLEN-1:0]   value_load,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_ready,
  output logic [XLEN-1:0]   if_inst,
  input  logic              clear_in,
  input  logic              io_buffer_full,
  input  logic [BYTE_W-1:0] mem_din,
  output logic [BYTE_W-1:0] mem_dout,
  output logic [XLEN-1:0]   mem_a,
  output logic              mem_wr
);

  mc_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  mc_req_t           req_q, req_d;
  logic [XLEN-1:0]   asm_q, asm_d;
  logic [1:0]        lane_q, lane_d;
  logic              load_done_q, load_done_d;
  logic              received_q, received_d;
  logic              has_result_q, has_result_d;
  logic              if_ready_q, if_ready_d;
  logic [XLEN-1:0]   mem_a_q, mem_a_d;
  logic [BYTE_W-1:0] mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;

  logic [1:0]        tx_lane;
  logic [1:0]        rx_lane;
  logic [BYTE_W-1:0] tx_byte;
  logic [XLEN-1:0]   rx_merged;
  logic [2:0]        last_cnt;

  // The last byte of a read arrives during the completion cycle, so it is merged on the fly there
  assign tx_lane  = 2'(cnt_q + 3'd1);
  assign rx_lane  = (state_q == MC_IDLE) ? lane_q : 2'(cnt_q - 3'd1);
  assign last_cnt = 3'(req_q.width - 3'd1);

  mem_byte_shift u_shift (
    .tx_word   (req_q.data),
    .tx_lane   (tx_lane),
    .rx_word   (asm_q),
    .rx_lane   (rx_lane),
    .rx_byte   (mem_din),
    .tx_byte   (tx_byte),
    .rx_merged (rx_merged)
  );

  assign received   = received_q;
  assign has_result = has_result_q;
  assign if_ready   = if_ready_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q;
  assign value_load = load_done_q ? rx_merged : '0;
  assign if_inst    = if_ready_q  ? rx_merged : '0;

  // Arbitration, byte sequencing and completion pulses
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    asm_d        = asm_q;
    lane_d       = lane_q;
    load_done_d  = load_done_q;
    received_d   = received_q;
    has_result_d = has_result_q;
    if_ready_d   = if_ready_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;

    if (rdy_in) begin
      received_d   = 1'b0;
      has_result_d = 1'b0;
      load_done_d  = 1'b0;
      if_ready_d   = 1'b0;
      mem_wr_d     = 1'b0;

      case (state_q)
        MC_IDLE: begin
          if (go_work && (width == W_NULL)) begin
            // Null op rides the load path with zero bytes and touches no RAM
            received_d  = 1'b1;
            req_d.width = W_NULL;
            cnt_d       = 3'd0;
            state_d     = MC_LOAD;
          end else if (go_work && l_or_s && (address >= IO_BASE) && io_buffer_full) begin
            // I/O store held off until the UART buffer drains
          end else if (go_work) begin
            received_d  = 1'b1;
            req_d.width = width;
            req_d.data  = value_store;
            asm_d       = '0;
            cnt_d       = 3'd0;
            mem_a_d     = address;
            if (l_or_s) begin
              mem_wr_d   = 1'b1;
              mem_dout_d = value_store[BYTE_W-1:0];
              state_d    = MC_STORE;
            end else begin
              state_d    = MC_LOAD;
            end
          end else if (if_req && !clear_in) begin
            req_d.width = 3'(FETCH_BYTES);
            asm_d       = '0;
            cnt_d       = 3'd0;
            mem_a_d     = if_addr;
            state_d     = MC_FETCH;
          end
        end

        MC_LOAD, MC_FETCH: begin
          if ((state_q == MC_FETCH) && clear_in) begin
            state_d = MC_IDLE;
          end else if (req_q.width == W_NULL) begin
            has_result_d = 1'b1;
            state_d      = MC_IDLE;
          end else begin
            if (cnt_q != 3'd0) asm_d = rx_merged;
            if (cnt_q == last_cnt) begin
              lane_d  = 2'(cnt_q);
              state_d = MC_IDLE;
              if (state_q == MC_LOAD) begin
                has_result_d = 1'b1;
                load_done_d  = 1'b1;
              end else begin
                if_ready_d   = 1'b1;
              end
            end else begin
              cnt_d   = 3'(cnt_q + 3'd1);
              mem_a_d = mem_a_q + 32'd1;
            end
          end
        end

        MC_STORE: begin
          if (cnt_q == last_cnt) begin
            has_result_d = 1'b1;
            state_d      = MC_IDLE;
          end else begin
            cnt_d      = 3'(cnt_q + 3'd1);
            mem_a_d    = mem_a_q + 32'd1;
            mem_dout_d = tx_byte;
            mem_wr_d   = 1'b1;
          end
        end

        default: state_d = MC_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= MC_IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      asm_q        <= '0;
      lane_q       <= '0;
      load_done_q  <= 1'b0;
      received_q   <= 1'b0;
      has_result_q <= 1'b0;
      if_ready_q   <= 1'b0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      asm_q        <= asm_d;
      lane_q       <= lane_d;
      load_done_q  <= load_done_d;
      received_q   <= received_d;
      has_result_q <= has_result_d;
      if_ready_q   <= if_ready_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: synchronous byte RAM, shadow memory model, directed and random traffic.
module tb_mem_ctrl;

  localparam int unsigned RAM_SZ  = 262144;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, go_work, l_or_s, if_req, clear_in, io_buffer_full;
  logic [2:0]  width;
  logic [31:0] address, value_store, if_addr;
  logic        received, has_result, if_ready, mem_wr;
  logic [31:0] value_load, if_inst, mem_a;
  logic [7:0]  mem_din, mem_dout;

  logic [7:0]  ram    [0:RAM_SZ-1];
  logic [7:0]  shadow [0:RAM_SZ-1];
  logic        fill;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .go_work(go_work), .l_or_s(l_or_s), .width(width), .address(address),
    .value_store(value_store), .received(received), .has_result(has_result),
    .value_load(value_load), .if_req(if_req), .if_addr(if_addr),
    .if_ready(if_ready), .if_inst(if_inst), .clear_in(clear_in),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  function automatic logic [7:0] pat(input int unsigned a);
    logic [31:0] t;
    case (a)
      32'h100: return 8'hEF;
      32'h101: return 8'hBE;
      32'h102: return 8'hAD;
      32'h103: return 8'hDE;
      default: begin
        t = a * 32'h9E37_79B1;
        return t[31:24];
      end
    endcase
  endfunction

  // RAM: read data appears the cycle after the address; writes land on the edge
  always @(posedge clk_in) begin
    if (fill) begin
      for (int i = 0; i < RAM_SZ; i++) ram[i] <= pat(i);
    end else if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
    end
    mem_din <= ram[mem_a[17:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] shadow_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = shadow[18'(a + 32'(i))];
    return w;
  endfunction

  // One LSB request; leaves the bench in the completion cycle
  task automatic do_data(input logic ls, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] v, output logic [31:0] got);
    logic [31:0] exp;
    bit seen;
    int n, wr_cycles, extra_rcv;
    got = '0;
    go_work = 1'b1; l_or_s = ls; width = w; address = a; value_store = v;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (received) seen = 1;
    end
    go_work = 1'b0;
    chk("received", 32'(seen), 32'd1);
    if (!seen) return;
    exp = ls ? 32'd0 : shadow_word(a, int'(w));
    if (ls) for (int i = 0; i < int'(w); i++) shadow[18'(a + 32'(i))] = v[8*i +: 8];
    seen = 0; n = 0; wr_cycles = 0; extra_rcv = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (mem_wr) wr_cycles++;
      if (k > 0 && received) extra_rcv++;
      if (has_result) begin
        seen = 1; n = k; got = value_load;
      end else begin
        tick();
      end
    end
    chk("has_result", 32'(seen), 32'd1);
    chk("latency", 32'(n), (w == 3'd0) ? 32'd1 : 32'(w));
    chk("value_load", got, exp);
    chk("mem_wr_cycles", 32'(wr_cycles), ls ? 32'(w) : 32'd0);
    chk("received_busy", 32'(extra_rcv), 32'd0);
  endtask

  // One fetch from idle; leaves the bench in the if_ready cycle
  task automatic do_fetch(input logic [31:0] a, output logic [31:0] got);
    int n, rcv, wr;
    got = '0; n = 0; rcv = 0; wr = 0;
    if_req = 1'b1; if_addr = a;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      tick();
      if (received) rcv++;
      if (mem_wr) wr++;
      if (if_ready) begin n = k; got = if_inst; end
    end
    if_req = 1'b0;
    chk("fetch_latency", 32'(n), 32'd5);
    chk("if_inst", got, shadow_word(a, 4));
    chk("fetch_side_effects", 32'(rcv + wr), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, a, v;
    logic [2:0]  w;
    logic        ls;
    int          n, r;

    rst_in = 1'b0; rdy_in = 1'b1; fill = 1'b1;
    go_work = 0; l_or_s = 0; width = 0; address = 0; value_store = 0;
    if_req = 0; if_addr = 0; clear_in = 0; io_buffer_full = 0;
    for (int i = 0; i < RAM_SZ; i++) shadow[i] = pat(i);

    #2;
    chk("rst_received", 32'(received), 32'd0);
    chk("rst_has_result", 32'(has_result), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_value_load", value_load, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    tick(); fill = 1'b0;
    tick(); rst_in = 1'b1;
    tick();

    // Word load of the known pattern
    do_data(1'b0, 3'd4, 32'h100, 32'd0, got);
    chk("deadbeef", got, 32'hDEAD_BEEF);

    // Misaligned half store
    do_data(1'b1, 3'd2, 32'h201, 32'h1234_5678, got);
    chk("ram_201", 32'(ram[18'h201]), 32'h78);
    chk("ram_202", 32'(ram[18'h202]), 32'h56);
    chk("ram_203", 32'(ram[18'h203]), 32'(shadow[18'h203]));

    // Data beats fetch when both arrive together
    tick();
    go_work = 1'b1; l_or_s = 1'b0; width = 3'd1; address = 32'h10;
    if_req = 1'b1; if_addr = 32'h0;
    tick();
    chk("prio_received", 32'(received), 32'd1);
    go_work = 1'b0;
    tick();
    chk("prio_has_result", 32'(has_result), 32'd1);
    chk("prio_value", value_load, shadow_word(32'h10, 1));
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      tick();
      if (if_ready) begin n = k; got = if_inst; end
    end
    if_req = 1'b0;
    chk("prio_fetch_latency", 32'(n), 32'd5);
    chk("prio_if_inst", got, shadow_word(32'h0, 4));

    // Flush aborts an in-flight fetch
    tick();
    if_req = 1'b1; if_addr = 32'h80;
    tick(); tick(); tick();
    clear_in = 1'b1; if_req = 1'b0;
    tick();
    clear_in = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (if_ready || mem_wr) n++;
      tick();
    end
    chk("flush_no_if_ready", 32'(n), 32'd0);
    do_fetch(32'h40, got);

    // I/O store gated by a full UART buffer
    tick();
    go_work = 1'b1; l_or_s = 1'b1; width = 3'd1; address = IO_BASE; value_store = 32'hA5;
    io_buffer_full = 1'b1;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (received || mem_wr) n++;
    end
    chk("io_gated", 32'(n), 32'd0);
    io_buffer_full = 1'b0;
    do_data(1'b1, 3'd1, IO_BASE, 32'hA5, got);
    chk("io_byte", 32'(ram[18'h30000]), 32'hA5);

    // Global stall in the middle of a load
    tick();
    go_work = 1'b1; l_or_s = 1'b0; width = 3'd4; address = 32'h120;
    tick();
    chk("stall_received", 32'(received), 32'd1);
    go_work = 1'b0; rdy_in = 1'b0;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (!received || has_result) n++;
    end
    chk("stall_hold", 32'(n), 32'd0);
    rdy_in = 1'b1;
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      tick();
      if (has_result) begin n = k; got = value_load; end
    end
    chk("stall_latency", 32'(n), 32'd4);
    chk("stall_value", got, shadow_word(32'h120, 4));

    // Random mix of loads, stores, null ops and fetches
    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 32'h3FFF0));
      repeat ($urandom_range(0, 2)) tick();
      if (r < 2) begin
        do_fetch(a, got);
      end else begin
        ls = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       w = 3'd0;
          1:       w = 3'd1;
          2:       w = 3'd2;
          default: w = 3'd4;
        endcase
        v = $urandom;
        io_buffer_full = (a < IO_BASE || !ls) ? 1'($urandom_range(0, 1)) : 1'b0;
        do_data(ls, w, a, v, got);
        io_buffer_full = 1'b0;
      end
    end
    n = 0;
    for (int i = 0; i < RAM_SZ; i++) if (ram[i] !== shadow[i]) n++;
    chk("ram_vs_shadow", 32'(n), 32'd0);

    // Asynchronous reset in the middle of a store
    tick();
    go_work = 1'b1; l_or_s = 1'b1; width = 3'd4; address = 32'h300; value_store = 32'hCAFE_F00D;
    tick();
    go_work = 1'b0;
    tick();
    chk("pre_rst_mem_wr", 32'(mem_wr), 32'd1);
    rst_in = 1'b0;
    #1;
    chk("async_rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("async_rst_mem_a", mem_a, 32'd0);
    tick(); tick();
    rst_in = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (has_result || mem_wr) n++;
    end
    chk("no_result_after_rst", 32'(n), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
